decoder_nto2n_seq: RTL and testbench

- Registered, parametrised N-to-2^N line decoder.
- Successor to the combinational 2-to-4 decoder with enable.
- Adds a valid/ready input handshake, selectable output polarity, and a sweep mode that strobes every output line in turn. Sweep mode is used for lamp/row scanning and self-test of downstream decode consumers.
- Sits between a control/sequencer block and per-line enables.

---
 rtl/decoder_nto2n_seq.sv | 85 ++++++++
 tb/tb_decoder_nto2n_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq: registered N-to-2^N decoder with valid/ready direct mode and a timed sweep mode
module decoder_nto2n_seq #(
  parameter int N = 3,
  parameter int ACTIVE_LOW = 0,
  parameter int SWEEP_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              en,
  input  logic [N-1:0]      sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic [(1<<N)-1:0] D,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);
  localparam int L = 1 << N;
  localparam int HW = $clog2(SWEEP_HOLD) + 1;
  localparam logic [L-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state;
  logic [N-1:0] idx;
  logic [HW-1:0] hc;
  function automatic logic [L-1:0] onehot(input logic [N-1:0] k);
    return INACT ^ ({{(L-1){1'b0}}, 1'b1} << k);
  endfunction
  assign in_ready = (state == IDLE) && !mode;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      D <= INACT;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      hc <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (mode && start) begin
            state <= SWEEP;
            busy <= 1'b1;
            D <= onehot('0);
            out_valid <= 1'b1;
            idx <= '0;
            hc <= '0;
          end else if (in_valid && in_ready) begin
            D <= en ? onehot(sel) : INACT;
            out_valid <= en;
          end
        end
        SWEEP: begin
          if (en) begin
            if (hc == HW'(SWEEP_HOLD - 1)) begin
              hc <= '0;
              // wrap of the last line is caught by compare so N never needs a carry bit
              if (idx == N'(L - 1)) begin
                state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
                D <= INACT;
                out_valid <= 1'b0;
                idx <= '0;
              end else begin
                idx <= idx + 1'b1;
                D <= onehot(idx + 1'b1);
              end
            end else begin
              hc <= hc + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// tb_decoder_nto2n_seq: scoreboard bench driving active-high and active-low decoders in lockstep
module tb_decoder_nto2n_seq;
  logic clk = 1'b0, rst, mode, en, in_valid, start;
  logic [2:0] sel;
  logic [7:0] d0, d1;
  logic rdy0, rdy1, ov0, ov1, bz0, bz1, dn0, dn1;
  int tests = 0, fails = 0;
  typedef struct packed {logic [7:0] d; logic ov, bz, dn;} exp_t;
  exp_t q[$];
  string tq[$];
  always #5 clk = ~clk;
  decoder_nto2n_seq #(.N(3), .ACTIVE_LOW(0), .SWEEP_HOLD(2)) u0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy0), .start(start), .D(d0), .out_valid(ov0), .busy(bz0), .done(dn0));
  decoder_nto2n_seq #(.N(3), .ACTIVE_LOW(1), .SWEEP_HOLD(2)) u1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy1), .start(start), .D(d1), .out_valid(ov1), .busy(bz1), .done(dn1));
  task automatic chk(input string t, input logic [7:0] o, input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic ov, input logic bz, input logic dn, input string t);
    q.push_back('{d, ov, bz, dn});
    tq.push_back(t);
  endtask
  task automatic cyc();
    exp_t e;
    string t;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      chk({t, ".D"}, d0, e.d);
      chk({t, ".D_low"}, d1, ~e.d);
      chk({t, ".out_valid"}, {7'd0, ov0}, {7'd0, e.ov});
      chk({t, ".out_valid_low"}, {7'd0, ov1}, {7'd0, e.ov});
      chk({t, ".busy"}, {7'd0, bz0}, {7'd0, e.bz});
      chk({t, ".done"}, {7'd0, dn0}, {7'd0, e.dn});
      chk({t, ".done_low"}, {7'd0, dn1}, {7'd0, e.dn});
    end
  endtask
  initial begin
    int ec, pc, len;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {mode, en, in_valid, start} = 4'($urandom);
      sel = 3'($urandom);
      push(8'h00, 0, 0, 0, "reset");
      cyc();
    end
    rst = 1'b0; mode = 1'b0; en = 1'b0; in_valid = 1'b0; start = 1'b0; sel = '0;
    #1;
    chk("reset.in_ready", {7'd0, rdy0}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; in_valid = 1'b1; sel = 3'(i);
      push(8'h01 << i, 1, 0, 0, $sformatf("direct%0d", i));
      cyc();
    end
    en = 1'b0; sel = 3'd5;
    push(8'h00, 0, 0, 0, "direct_en0");
    cyc();
    in_valid = 1'b0; en = 1'b1; sel = 3'd3;
    push(8'h00, 0, 0, 0, "no_transfer");
    cyc();
    in_valid = 1'b1; sel = 3'd2;
    push(8'h04, 1, 0, 0, "direct_sel2");
    cyc();
    in_valid = 1'b0; start = 1'b1;
    push(8'h04, 1, 0, 0, "start_mode0_ignored");
    cyc();
    mode = 1'b1;
    #1;
    chk("sweep.in_ready", {7'd0, rdy0}, 8'd0);
    push(8'h01, 1, 1, 0, "sweep1");
    cyc();
    start = 1'b0;
    for (int j = 2; j <= 16; j++) begin
      push(8'h01 << ((j - 1) / 2), 1, 1, 0, $sformatf("sweep%0d", j));
      cyc();
      chk("sweep.in_ready_busy", {7'd0, rdy0}, 8'd0);
    end
    push(8'h00, 0, 0, 1, "sweep_done");
    cyc();
    mode = 1'b0;
    push(8'h00, 0, 0, 0, "sweep_idle");
    cyc();
    chk("after_sweep.in_ready", {7'd0, rdy0}, 8'd1);
    mode = 1'b1; start = 1'b1; en = 1'b1;
    push(8'h01, 1, 1, 0, "pause_start");
    cyc();
    start = 1'b0;
    ec = 0; pc = 0; len = 1;
    while (ec < 16) begin
      en = !(ec == 7 && pc < 4);
      if (!en) pc++;
      in_valid = 1'($urandom); start = 1'($urandom); mode = 1'($urandom); sel = 3'($urandom);
      if (en) ec++;
      if (ec < 16) push(8'h01 << (ec / 2), 1, 1, 0, $sformatf("pause_ec%0d", ec));
      else push(8'h00, 0, 0, 1, "pause_done");
      cyc();
      len++;
    end
    chk("pause.length", 8'(len), 8'd21);
    start = 1'b0; in_valid = 1'b0; mode = 1'b1; en = 1'b1;
    push(8'h00, 0, 0, 0, "pause_idle");
    cyc();
    start = 1'b1;
    push(8'h01, 1, 1, 0, "abort_start");
    cyc();
    start = 1'b0;
    for (int j = 2; j <= 9; j++) begin
      push(8'h01 << ((j - 1) / 2), 1, 1, 0, $sformatf("abort%0d", j));
      cyc();
    end
    chk("abort.D_before_rst", d0, 8'h10);
    rst = 1'b1;
    push(8'h00, 0, 0, 0, "abort_rst");
    cyc();
    rst = 1'b0; mode = 1'b0;
    for (int j = 0; j < 3; j++) begin
      push(8'h00, 0, 0, 0, "abort_no_done");
      cyc();
    end
    in_valid = 1'b1; en = 1'b1; sel = 3'd1;
    push(8'h02, 1, 0, 0, "abort_direct");
    cyc();
    in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
